// File: rtl/pong_game_ctrl.sv
// Board constants plus the pong match sequencer. The sequencer debounces the keys,
// runs the match FSM, keeps both scores, gates motion and drives the LEDs.
package board_pkg;
    localparam int BOARD_CLK_MHZ = 50;
    localparam int KEYS_W        = 4;
    localparam int LEDS_W        = 8;
endpackage

module pong_game_ctrl #(
    parameter int CLK_MHZ      = board_pkg::BOARD_CLK_MHZ,
    parameter int KEYS_W       = board_pkg::KEYS_W,
    parameter int LEDS_W       = board_pkg::LEDS_W,
    parameter int DEBOUNCE_MS  = 10,
    parameter int WIN_SCORE    = 5,
    parameter int SCORE_W      = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [KEYS_W-1:0]  keys_i,
    input  logic               frame_tick_i,
    input  logic               miss_l_i,
    input  logic               miss_r_i,
    output logic [KEYS_W-1:0]  keys_db_o,
    output logic               run_o,
    output logic               serve_o,
    output logic               serve_dir_o,
    output logic [SCORE_W-1:0] score_l_o,
    output logic [SCORE_W-1:0] score_r_o,
    output logic [2:0]         state_o,
    output logic [LEDS_W-1:0]  leds_o
);

    localparam int MS_CYC = CLK_MHZ * 1000;
    localparam int MS_W   = $clog2(MS_CYC);
    localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
    localparam int FR_W   = $clog2(SERVE_FRAMES + 1);

    localparam logic [MS_W-1:0]    MS_LAST = MS_W'(MS_CYC - 1);
    localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [FR_W-1:0]    FR_LAST = FR_W'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    logic [KEYS_W-1:0] r_sync1;
    logic [KEYS_W-1:0] r_sync2;
    logic [KEYS_W-1:0] r_keys_db;
    logic [DB_W-1:0]   r_db_cnt [KEYS_W];
    logic [MS_W-1:0]   r_ms_cnt;
    logic              r_db0_d;
    logic              w_ms_tick;
    logic              w_start;

    assign w_ms_tick = (r_ms_cnt == MS_LAST);
    assign w_start   = r_keys_db[0] & ~r_db0_d;

    // A key's debounced level flips only after DEBOUNCE_MS consecutive ms ticks of disagreement
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_keys_db <= '0;
            r_ms_cnt  <= '0;
            r_db0_d   <= 1'b0;
            for (int k = 0; k < KEYS_W; k++) r_db_cnt[k] <= '0;
        end else begin
            r_sync1  <= keys_i;
            r_sync2  <= r_sync1;
            r_ms_cnt <= w_ms_tick ? '0 : r_ms_cnt + 1'b1;
            r_db0_d  <= r_keys_db[0];
            for (int k = 0; k < KEYS_W; k++) begin
                if (r_sync2[k] == r_keys_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (w_ms_tick) begin
                    if (r_db_cnt[k] == DB_LAST) begin
                        r_keys_db[k] <= r_sync2[k];
                        r_db_cnt[k]  <= '0;
                    end else begin
                        r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    state_t             r_state, w_state_nxt;
    logic [FR_W-1:0]    r_frame_cnt, w_frame_nxt;
    logic [SCORE_W-1:0] r_score_l, w_score_l_nxt;
    logic [SCORE_W-1:0] r_score_r, w_score_r_nxt;
    logic [SCORE_W-1:0] w_inc_l, w_inc_r;
    logic               r_dir, w_dir_nxt;
    logic               r_serve, w_serve_nxt;
    logic               r_run;
    logic [3:0]         r_blink_cnt, w_blink_cnt_nxt;
    logic               r_blink, w_blink_nxt;
    logic [LEDS_W-1:0]  r_leds, w_leds_nxt;

    assign w_inc_l = r_score_l + 1'b1;
    assign w_inc_r = r_score_r + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= '0;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_dir       <= 1'b1;
            r_serve     <= 1'b0;
            r_run       <= 1'b0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
            r_leds      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_score_l   <= w_score_l_nxt;
            r_score_r   <= w_score_r_nxt;
            r_dir       <= w_dir_nxt;
            r_serve     <= w_serve_nxt;
            r_run       <= (w_state_nxt == S_PLAY);
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink     <= w_blink_nxt;
            r_leds      <= w_leds_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_nxt     = r_frame_cnt;
        w_score_l_nxt   = r_score_l;
        w_score_r_nxt   = r_score_r;
        w_dir_nxt       = r_dir;
        w_serve_nxt     = 1'b0;
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_nxt     = r_blink;
        w_leds_nxt      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_SERVE;
                    w_frame_nxt = '0;
                end
            end
            S_SERVE: begin
                if (frame_tick_i) begin
                    if (r_frame_cnt == FR_LAST) begin
                        w_state_nxt = S_PLAY;
                        w_serve_nxt = 1'b1;
                        w_frame_nxt = '0;
                    end else begin
                        w_frame_nxt = r_frame_cnt + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                // Left miss takes precedence; any miss swallows a coincident start
                if (miss_l_i) begin
                    w_score_r_nxt = w_inc_r;
                    w_dir_nxt     = 1'b0;
                    w_frame_nxt   = '0;
                    w_state_nxt   = (w_inc_r == WIN) ? S_OVER : S_SERVE;
                end else if (miss_r_i) begin
                    w_score_l_nxt = w_inc_l;
                    w_dir_nxt     = 1'b1;
                    w_frame_nxt   = '0;
                    w_state_nxt   = (w_inc_l == WIN) ? S_OVER : S_SERVE;
                end else if (w_start) begin
                    w_state_nxt = S_PAUSE;
                end
                if (w_state_nxt == S_OVER) begin
                    w_blink_cnt_nxt = '0;
                    w_blink_nxt     = 1'b1;
                end
            end
            S_PAUSE: begin
                if (w_start) w_state_nxt = S_PLAY;
            end
            S_OVER: begin
                if (w_start) begin
                    w_state_nxt   = S_IDLE;
                    w_score_l_nxt = '0;
                    w_score_r_nxt = '0;
                end else if (frame_tick_i) begin
                    w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                    if (r_blink_cnt == 4'hF) w_blink_nxt = ~r_blink;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_leds_nxt[0] = (w_state_nxt == S_PLAY);
        w_leds_nxt[1] = (w_state_nxt == S_PAUSE) | ((w_state_nxt == S_OVER) & w_blink_nxt);
    end

    assign keys_db_o   = r_keys_db;
    assign run_o       = r_run;
    assign serve_o     = r_serve;
    assign serve_dir_o = r_dir;
    assign score_l_o   = r_score_l;
    assign score_r_o   = r_score_r;
    assign state_o     = r_state;
    assign leds_o      = r_leds;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scenario bench for pong_game_ctrl: expected output records are queued when a
// stimulus is applied and popped when the DUT reaches the corresponding result.
module tb_pong_game_ctrl;

    localparam int KW = 2;
    localparam int LW = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [KW-1:0] keys;
    logic          frame_tick;
    logic          miss_l;
    logic          miss_r;
    logic [KW-1:0] keys_db;
    logic          run;
    logic          serve;
    logic          serve_dir;
    logic [SW-1:0] score_l;
    logic [SW-1:0] score_r;
    logic [2:0]    state;
    logic [LW-1:0] leds;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0]    state;
        logic          run;
        logic          serve;
        logic          dir;
        logic [SW-1:0] sl;
        logic [SW-1:0] sr;
        logic [LW-1:0] leds;
    } exp_t;

    exp_t exp_q[$];

    pong_game_ctrl #(
        .CLK_MHZ(1), .KEYS_W(KW), .LEDS_W(LW), .DEBOUNCE_MS(2),
        .WIN_SCORE(2), .SCORE_W(SW), .SERVE_FRAMES(3)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .keys_i(keys), .frame_tick_i(frame_tick),
        .miss_l_i(miss_l), .miss_r_i(miss_r), .keys_db_o(keys_db), .run_o(run),
        .serve_o(serve), .serve_dir_o(serve_dir), .score_l_o(score_l),
        .score_r_o(score_r), .state_o(state), .leds_o(leds)
    );

    always #5 clk = ~clk;

    // Frame tick every 50 cycles, changed on the falling edge
    initial begin
        frame_tick = 1'b0;
        forever begin
            repeat (49) @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t observe();
        exp_t o;
        o.state = state; o.run = run; o.serve = serve; o.dir = serve_dir;
        o.sl = score_l; o.sr = score_r; o.leds = leds;
        return o;
    endfunction

    function automatic exp_t mk(input logic [2:0] st, input logic rn, input logic sv,
                                input logic dr, input int sl, input int sr,
                                input logic [LW-1:0] ld);
        exp_t e;
        e.state = st; e.run = rn; e.serve = sv; e.dir = dr;
        e.sl = SW'(sl); e.sr = SW'(sr); e.leds = ld;
        return e;
    endfunction

    task automatic press_until_change(input logic [2:0] from_st);
        keys[0] = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if (state !== from_st) break;
        end
    endtask

    task automatic release_key();
        keys[0] = 1'b0;
        repeat (3000) cyc();
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        miss_l = l;
        miss_r = r;
        cyc();
        miss_l = 1'b0;
        miss_r = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, o;
        int   waited;
        bit   got;
        keys = '0; keys[0] = 1'b1; miss_l = 1'b0; miss_r = 1'b0; rst_n = 1'b0;
        exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b1, 0, 0, 4'b0000));
        repeat (5) cyc();
        e = exp_q.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL reset_outputs: got %h required %h", o, e); end
        n_checks++;
        if (keys_db !== '0) begin n_fail++; $display("FAIL reset_keys_db: got %b required 0", keys_db); end
        rst_n = 1'b1;
        waited = 0;
        while (keys_db[0] !== 1'b1 && waited < 4000) begin cyc(); waited++; end
        n_checks++;
        if (waited < 1990 || waited > 3010) begin
            n_fail++; $display("FAIL held_key_latency: got %0d cycles required 1990..3010", waited);
        end
        for (int i = 0; i < 5 && state !== 3'd1; i++) cyc();
        n_checks++;
        if (state !== 3'd1) begin n_fail++; $display("FAIL held_key_serve: got state %0d required 1", state); end
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin cyc(); got = serve; end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL held_key_launch: got no serve pulse required one"); end
        release_key();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_bounce();
        int bad = 0;
        int rises = 0;
        logic prev = 1'b0;
        for (int p = 0; p < 4; p++) begin
            keys[0] = (p % 2 == 0);
            repeat (1000) begin
                cyc();
                if (keys_db[0] !== 1'b0 || state !== 3'd0) bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL bounce_quiet: got %0d disturbed cycles required 0", bad); end
        keys[0] = 1'b1;
        for (int i = 0; i < 3000 && state === 3'd0; i++) begin
            cyc();
            if (keys_db[0] === 1'b1 && prev === 1'b0) rises++;
            prev = keys_db[0];
        end
        n_checks++;
        if (state !== 3'd1 || rises != 1) begin
            n_fail++; $display("FAIL bounce_start: got state %0d rises %0d required state 1 rises 1", state, rises);
        end
    endtask

    task automatic test_serve(input exp_t e_play);
        exp_t e, o;
        int   ticks = 0;
        bit   got = 1'b0;
        exp_q.push_back(e_play);
        for (int i = 0; i < 300 && !got; i++) begin
            cyc();
            if (frame_tick) ticks++;
            got = serve;
        end
        e = exp_q.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL serve_launch: got %h required %h", o, e); end
        n_checks++;
        if (ticks != 3) begin n_fail++; $display("FAIL serve_ticks: got %0d required 3", ticks); end
        cyc();
        n_checks++;
        if (serve !== 1'b0) begin n_fail++; $display("FAIL serve_one_cycle: got %b required 0", serve); end
    endtask

    task automatic test_single_start();
        release_key();
        n_checks++;
        if (state !== 3'd2 || run !== 1'b1) begin
            n_fail++; $display("FAIL single_start: got state %0d run %b required 2 1", state, run);
        end
    endtask

    task automatic test_miss_both();
        exp_t e, o;
        exp_q.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 0, 1, 4'b0000));
        pulse_miss(1'b1, 1'b1);
        e = exp_q.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL miss_both: got %h required %h", o, e); end
        test_serve(mk(3'd2, 1'b1, 1'b1, 1'b0, 0, 1, 4'b0001));
    endtask

    task automatic test_game_over();
        exp_t e, o;
        int   ticks = 0;
        exp_q.push_back(mk(3'd4, 1'b0, 1'b0, 1'b0, 0, 2, 4'b0010));
        pulse_miss(1'b1, 1'b0);
        e = exp_q.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL game_over: got %h required %h", o, e); end
        for (int i = 0; i < 1000 && ticks < 16; i++) begin
            cyc();
            if (frame_tick) begin
                ticks++;
                if (ticks == 15) begin
                    n_checks++;
                    if (leds !== 4'b0010) begin n_fail++; $display("FAIL blink_hold: got %b required 0010", leds); end
                end
                if (ticks == 16) begin
                    n_checks++;
                    if (leds !== 4'b0000 || state !== 3'd4) begin
                        n_fail++; $display("FAIL blink_toggle: got leds %b state %0d required 0000 4", leds, state);
                    end
                end
            end
        end
        exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0000));
        press_until_change(3'd4);
        e = exp_q.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL over_to_idle: got %h required %h", o, e); end
        release_key();
    endtask

    task automatic test_pause();
        exp_t e, o;
        press_until_change(3'd0);
        n_checks++;
        if (state !== 3'd1) begin n_fail++; $display("FAIL pause_setup: got state %0d required 1", state); end
        test_serve(mk(3'd2, 1'b1, 1'b1, 1'b0, 0, 0, 4'b0001));
        release_key();
        exp_q.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0010));
        press_until_change(3'd2);
        e = exp_q.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL enter_pause: got %h required %h", o, e); end
        exp_q.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0010));
        pulse_miss(1'b0, 1'b1);
        cyc();
        e = exp_q.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL pause_miss_ignored: got %h required %h", o, e); end
        release_key();
        exp_q.push_back(mk(3'd2, 1'b1, 1'b0, 1'b0, 0, 0, 4'b0001));
        press_until_change(3'd3);
        e = exp_q.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL resume_play: got %h required %h", o, e); end
        release_key();
    endtask

    task automatic test_reset_mid_serve();
        exp_t e, o;
        int   seen = 0;
        exp_q.push_back(mk(3'd1, 1'b0, 1'b0, 1'b1, 1, 0, 4'b0000));
        pulse_miss(1'b0, 1'b1);
        e = exp_q.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL miss_right: got %h required %h", o, e); end
        repeat (10) cyc();
        exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b1, 0, 0, 4'b0000));
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        e = exp_q.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL reset_mid_serve: got %h required %h", o, e); end
        repeat (300) begin
            cyc();
            if (serve !== 1'b0 || state !== 3'd0) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL idle_after_reset: got %0d active cycles required 0", seen); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_serve(mk(3'd2, 1'b1, 1'b1, 1'b1, 0, 0, 4'b0001));
        test_single_start();
        test_miss_both();
        test_game_over();
        test_pause();
        test_reset_mid_serve();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
